// File: rtl/spi_prog_loader.sv
// SPI-slave program loader: receives a base address followed by data words over
// mode-0 SPI and turns each completed word into a memory write request.
module spi_prog_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  spi_ss_i,
    input  logic                  spi_sclk_i,
    input  logic                  spi_mosi_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  clr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o,
    output logic                  frame_err_o,
    output logic [15:0]           word_cnt_o
);

    localparam int MAX_W = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
    localparam int CNT_W = $clog2(MAX_W) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    logic [2:0]              ss_sync_r;
    logic [2:0]              sclk_sync_r;
    logic [1:0]              mosi_sync_r;
    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [MAX_W-2:0]        shift_r;
    logic [MAX_W-1:0]        shift_nxt_s;
    logic [CNT_W-1:0]        bit_cnt_r;
    logic [ADDR_WIDTH-1:0]   base_r;
    logic [ADDR_WIDTH-3:0]   word_idx_r;
    logic [15:0]             word_cnt_r;
    logic                    mem_req_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [DATA_WIDTH-1:0]   mem_wdata_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    overflow_r;
    logic                    frame_err_r;

    logic ss_s;
    logic ss_fall_s;
    logic ss_rise_s;
    logic sclk_rise_s;
    logic mosi_s;
    logic shift_en_s;
    logic frame_end_s;
    logic frame_err_set_s;
    logic word_done_s;
    logic req_load_s;
    logic req_nxt_s;
    logic overflow_set_s;

    // Bring the asynchronous SPI pins into clk_i; third ss/sclk stage feeds edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ss_sync_r   <= 3'b111;
            sclk_sync_r <= 3'b000;
            mosi_sync_r <= 2'b00;
        end else begin
            ss_sync_r   <= {ss_sync_r[1:0], spi_ss_i};
            sclk_sync_r <= {sclk_sync_r[1:0], spi_sclk_i};
            mosi_sync_r <= {mosi_sync_r[0], spi_mosi_i};
        end
    end

    assign ss_s        = ss_sync_r[1];
    assign ss_fall_s   = ss_sync_r[2] & ~ss_sync_r[1];
    assign ss_rise_s   = ~ss_sync_r[2] & ss_sync_r[1];
    assign sclk_rise_s = ~sclk_sync_r[2] & sclk_sync_r[1];
    assign mosi_s      = mosi_sync_r[1];

    assign shift_nxt_s     = {shift_r, mosi_s};
    assign shift_en_s      = ~ss_s & sclk_rise_s & (state_r != ST_IDLE);
    assign frame_end_s     = ss_rise_s & (state_r != ST_IDLE);
    assign frame_err_set_s = frame_end_s & ((state_r == ST_ADDR) | (bit_cnt_r != CNT_ZERO));
    assign word_done_s     = shift_en_s & (state_r == ST_DATA) & (bit_cnt_r == DATA_LAST);
    // A grant in the same cycle frees the slot, so the new word may load without overflow
    assign req_load_s      = word_done_s & (~mem_req_r | mem_gnt_i);
    assign req_nxt_s       = req_load_s | (mem_req_r & ~mem_gnt_i);
    assign overflow_set_s  = word_done_s & mem_req_r & ~mem_gnt_i;

    // Next-state selection for the frame FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ss_fall_s) begin
                    state_nxt_s = ST_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (ss_rise_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (shift_en_s && (bit_cnt_r == ADDR_LAST)) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (ss_rise_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Frame FSM, shift/count datapath, write request and status registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            shift_r     <= '0;
            bit_cnt_r   <= CNT_ZERO;
            base_r      <= '0;
            word_idx_r  <= '0;
            word_cnt_r  <= 16'd0;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            overflow_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE) | req_nxt_s;
            done_r  <= frame_end_s;

            case (state_r)
                ST_IDLE: begin
                    if (ss_fall_s) begin
                        shift_r    <= '0;
                        bit_cnt_r  <= CNT_ZERO;
                        word_idx_r <= '0;
                        word_cnt_r <= 16'd0;
                    end
                end
                ST_ADDR: begin
                    if (shift_en_s) begin
                        shift_r <= shift_nxt_s[MAX_W-2:0];
                        if (bit_cnt_r == ADDR_LAST) begin
                            base_r    <= {shift_nxt_s[ADDR_WIDTH-1:2], 2'b00};
                            bit_cnt_r <= CNT_ZERO;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_DATA: begin
                    if (shift_en_s) begin
                        shift_r <= shift_nxt_s[MAX_W-2:0];
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_r  <= CNT_ZERO;
                            word_idx_r <= word_idx_r + (ADDR_WIDTH-2)'(1);
                            if (word_cnt_r != 16'hFFFF) begin
                                word_cnt_r <= word_cnt_r + 16'd1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        end
                    end
                end
                default: begin
                    bit_cnt_r <= CNT_ZERO;
                end
            endcase

            mem_req_r <= req_nxt_s;
            if (req_load_s) begin
                mem_addr_r  <= base_r + {word_idx_r, 2'b00};
                mem_wdata_r <= shift_nxt_s[DATA_WIDTH-1:0];
            end

            if (clr_i) begin
                overflow_r  <= 1'b0;
                frame_err_r <= 1'b0;
            end else begin
                if (overflow_set_s) begin
                    overflow_r <= 1'b1;
                end
                if (frame_err_set_s) begin
                    frame_err_r <= 1'b1;
                end
            end
        end
    end

    assign mem_req_o   = mem_req_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign overflow_o  = overflow_r;
    assign frame_err_o = frame_err_r;
    assign word_cnt_o  = word_cnt_r;

endmodule

// File: doc/spi_prog_loader.md
SPI_PROG_LOADER -- requirements
Module: spi_prog_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of the SPI data word and of mem_wdata_o.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning the width of the SPI address word and of mem_addr_o.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port spi_ss_i, input, 1 bit: SPI slave select, active-low, asynchronous to clk_i.
REQ-006 SHALL have port spi_sclk_i, input, 1 bit: SPI serial clock, mode 0, asynchronous to clk_i.
REQ-007 SHALL have port spi_mosi_i, input, 1 bit: SPI serial data, MSB first.
REQ-008 SHALL have port mem_req_o, output, 1 bit: memory write request valid.
REQ-009 SHALL have port mem_addr_o, output, ADDR_WIDTH bits: write byte address.
REQ-010 SHALL have port mem_wdata_o, output, DATA_WIDTH bits: write data.
REQ-011 SHALL have port mem_gnt_i, input, 1 bit: memory accepts the request.
REQ-012 SHALL have port clr_i, input, 1 bit: clears the sticky error flags.
REQ-013 SHALL have port busy_o, output, 1 bit: a frame is in progress.
REQ-014 SHALL have port done_o, output, 1 bit: one-cycle pulse at frame end.
REQ-015 SHALL have port overflow_o, output, 1 bit: sticky flag, a word was dropped.
REQ-016 SHALL have port frame_err_o, output, 1 bit: sticky flag, a frame ended on a partial word.
REQ-017 SHALL have port word_cnt_o, output, 16 bits: data words received in the current or last frame.

Function
REQ-018 SHALL pass spi_ss_i, spi_sclk_i and spi_mosi_i each through a 2-flop synchronizer, with one further register for edge detection.
REQ-019 SHALL be correct only when spi_sclk_i high time and low time are each at least 2 clk_i periods; faster SCLK is unsupported.
REQ-020 SHALL implement state machine IDLE -> ADDR -> DATA.
- A synchronized falling edge of ss moves IDLE to ADDR.
- It clears the bit counter and word_cnt_o.
REQ-021 SHALL shift synchronized mosi into a shift register, MSB first, on each synchronized rising edge of sclk while ss is low.
REQ-022 SHALL, in ADDR, after ADDR_WIDTH bits, latch the shifted value as the base address and move to DATA.
- The low 2 address bits are forced to 0.
REQ-023 SHALL, in DATA, on each completed DATA_WIDTH-bit word:
- load mem_wdata_o and mem_addr_o, with mem_addr_o = base + 4*word_index;
- assert mem_req_o on the clk_i cycle after the detected final rising edge;
- increment word_cnt_o, which saturates at 0xFFFF.
REQ-024 SHALL hold mem_req_o, mem_addr_o and mem_wdata_o stable until a cycle in which mem_req_o and mem_gnt_i are both high; mem_req_o deasserts in the next cycle.
REQ-025 SHALL handle a word completing while a request is still ungranted as follows: drop the new word, set overflow_o, leave the pending request unchanged, and still advance word_index and word_cnt_o.
REQ-026 SHALL allow a completing word to load a new request in the same cycle that the previous request is granted; this is not an overflow.
REQ-027 SHALL, on a synchronized rising edge of ss in ADDR or DATA:
- return to IDLE and pulse done_o for one cycle;
- set frame_err_o if the bit counter is nonzero (partial word) or the state is ADDR;
- discard any partial word.
REQ-028 SHALL let a pending mem_req_o survive frame end until granted.
REQ-029 SHALL drive busy_o high in ADDR or DATA, or while mem_req_o is high.
REQ-030 SHALL give clr_i priority over a simultaneous set event: clr_i clears overflow_o and frame_err_o regardless.
REQ-031 SHALL ignore sclk edges while ss is high.
REQ-032 SHALL ignore an ss falling edge while not in IDLE.
REQ-033 SHALL wrap the address modulo 2^ADDR_WIDTH.

Reset
REQ-034 SHALL, while rst_i is high at a clk_i edge, force:
- state to IDLE;
- mem_req_o, busy_o, done_o, overflow_o and frame_err_o to 0;
- word_cnt_o, mem_addr_o, mem_wdata_o and all shift and counter registers to 0;
- all synchronizer flops to the idle line levels (ss=1, sclk=0, mosi=0).
REQ-035 SHALL abort any in-progress frame on reset mid-frame, with no done_o pulse.
REQ-036 SHALL, after reset, require a fresh ss falling edge before accepting bits.

Verification
REQ-037 SHALL cover single word: address 0x00000100 and data 0xDEADBEEF with mem_gnt_i tied high -> exactly one mem_req_o cycle with addr 0x100 and data 0xDEADBEEF, then done_o pulse, word_cnt_o=1, no flags.
REQ-038 SHALL cover burst: address 0x00000000 and 4 words 0x11111111 to 0x44444444 -> requests at 0x0, 0x4, 0x8, 0xC in order, word_cnt_o=4.
REQ-039 SHALL cover backpressure: mem_gnt_i held low through the second word of 2 -> first request held stable, overflow_o=1, word_cnt_o=2, one request only; clr_i then clears overflow_o.
REQ-040 SHALL cover a partial word: ss deasserted after 40 bits -> no request for the partial word, frame_err_o=1, done_o pulses.
REQ-041 SHALL cover reset mid-frame: rst_i high after 20 data bits, then a full frame with address 0x200 and data 0xCAFEF00D -> only addr 0x200 is written, flags 0.
REQ-042 SHALL cover address wrap: address 0xFFFFFFFC and 2 words -> writes at 0xFFFFFFFC, then 0x00000000.
